// File: rtl/mem_port_arbiter.sv
// Shares one single-ported, variable-latency memory between instruction fetch and data access.
// Optional fetch anti-starvation rule is enabled by defining MEM_ARB_FAIRNESS_EN.
module mem_port_arbiter #(
   parameter int unsigned ADDR_W       = 32,
   parameter int unsigned DATA_W       = 32,
   parameter int unsigned STARVE_LIMIT = 4
) (
   input  logic                clk,
   input  logic                rst,
   input  logic                if_req,
   input  logic [ADDR_W-1:0]   if_addr,
   input  logic                if_flush,
   output logic                if_ack,
   output logic [DATA_W-1:0]   if_rdata,
   input  logic                dm_req,
   input  logic                dm_we,
   input  logic [ADDR_W-1:0]   dm_addr,
   input  logic [DATA_W-1:0]   dm_wdata,
   input  logic [DATA_W/8-1:0] dm_wstrb,
   output logic                dm_ack,
   output logic [DATA_W-1:0]   dm_rdata,
   output logic                if_stall,
   output logic                dm_stall,
   output logic                mem_req,
   output logic                mem_we,
   output logic [ADDR_W-1:0]   mem_addr,
   output logic [DATA_W-1:0]   mem_wdata,
   output logic [DATA_W/8-1:0] mem_wstrb,
   input  logic                mem_gnt,
   input  logic                mem_rvalid,
   input  logic [DATA_W-1:0]   mem_rdata
);

   typedef enum logic [1:0] {S_IDLE, S_REQ, S_RESP} state_t;
   typedef enum logic {OWN_IF, OWN_DM} owner_t;

   state_t state;
   owner_t owner;
   logic   drop;

   logic fetch_pend;
   logic grant_if;
   logic grant_dm;

   // A fetch being flushed this cycle is not eligible for arbitration.
   assign fetch_pend = if_req & ~if_flush;

`ifdef MEM_ARB_FAIRNESS_EN
   localparam int unsigned CNT_W = $clog2(STARVE_LIMIT + 1);

   logic [CNT_W-1:0] streak;
   logic             starved;

   assign starved  = (streak == CNT_W'(STARVE_LIMIT));
   assign grant_if = fetch_pend & (~dm_req | starved);

   // Counts DM grants that overtook a waiting fetch.
   always_ff @(posedge clk) begin
      if (rst) begin
         streak <= '0;
      end else if (state == S_IDLE) begin
         if (grant_if || !fetch_pend) begin
            streak <= '0;
         end else if (grant_dm) begin
            streak <= streak + CNT_W'(1);
         end
      end
   end
`else
   logic unused_starve_limit;

   assign grant_if            = fetch_pend & ~dm_req;
   assign unused_starve_limit = (STARVE_LIMIT == 0);
`endif

   assign grant_dm = dm_req & ~grant_if;

   // Transaction FSM: one outstanding access, fields held until the response.
   always_ff @(posedge clk) begin
      if (rst) begin
         state     <= S_IDLE;
         owner     <= OWN_IF;
         drop      <= 1'b0;
         mem_req   <= 1'b0;
         mem_we    <= 1'b0;
         mem_addr  <= '0;
         mem_wdata <= '0;
         mem_wstrb <= '0;
      end else begin
         case (state)
            S_IDLE: begin
               if (grant_dm) begin
                  owner     <= OWN_DM;
                  drop      <= 1'b0;
                  mem_req   <= 1'b1;
                  mem_we    <= dm_we;
                  mem_addr  <= dm_addr;
                  mem_wdata <= dm_wdata;
                  mem_wstrb <= dm_wstrb;
                  state     <= S_REQ;
               end else if (grant_if) begin
                  owner     <= OWN_IF;
                  drop      <= 1'b0;
                  mem_req   <= 1'b1;
                  mem_we    <= 1'b0;
                  mem_addr  <= if_addr;
                  mem_wdata <= '0;
                  mem_wstrb <= '0;
                  state     <= S_REQ;
               end
            end
            S_REQ: begin
               if (if_flush && owner == OWN_IF) begin
                  drop <= 1'b1;
               end
               if (mem_gnt) begin
                  mem_req <= 1'b0;
                  state   <= S_RESP;
               end
            end
            S_RESP: begin
               if (if_flush && owner == OWN_IF) begin
                  drop <= 1'b1;
               end
               if (mem_rvalid) begin
                  state <= S_IDLE;
               end
            end
            default: begin
               state   <= S_IDLE;
               mem_req <= 1'b0;
            end
         endcase
      end
   end

   logic resp_hit;

   // Responses pass straight through so the requester sees data in the rvalid cycle.
   assign resp_hit = (state == S_RESP) & mem_rvalid;
   assign dm_ack   = resp_hit & (owner == OWN_DM);
   assign if_ack   = resp_hit & (owner == OWN_IF) & ~drop & ~if_flush;
   assign dm_rdata = {DATA_W{dm_ack}} & mem_rdata;
   assign if_rdata = {DATA_W{if_ack}} & mem_rdata;
   assign if_stall = if_req & ~if_ack;
   assign dm_stall = dm_req & ~dm_ack;

endmodule
